// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode hex display driver with a double-buffered
// value/dp register, per-digit dwell prescaler and optional leading-zero blanking.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DivW = $clog2(REFRESH_DIV);

  logic [DivW-1:0]         div_q, div_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_value_q, pend_value_d, disp_value_q, disp_value_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [6:0]              seg_n_q, seg_n_d;
  logic                    dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic                    frame_done_q, frame_done_d;

  logic       term, last_digit, boundary, upper_zero, blank;
  logic [3:0] nibble;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return g;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    term         = (div_q == DivW'(REFRESH_DIV - 1));
    last_digit   = (idx_q == IdxW'(NUM_DIGITS - 1));
    boundary     = term && last_digit;
    div_d        = term ? '0 : div_q + DivW'(1);
    idx_d        = idx_q;
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_value_d = disp_value_q;
    disp_dp_d    = disp_dp_q;
    frame_done_d = boundary;

    if (term) idx_d = last_digit ? '0 : idx_q + IdxW'(1);

    // A load on the boundary goes straight to display; the stale pending copy
    // is left untouched because pend_valid is cleared anyway.
    if (boundary) begin
      pend_valid_d = 1'b0;
      if (load) begin
        disp_value_d = value;
        disp_dp_d    = dp;
      end else if (pend_valid_q) begin
        disp_value_d = pend_value_q;
        disp_dp_d    = pend_dp_q;
      end
    end else if (load) begin
      pend_value_d = value;
      pend_dp_d    = dp;
      pend_valid_d = 1'b1;
    end

    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx_q) && disp_value_q[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    blank  = blank_lz && (idx_q != '0) && upper_zero;
    nibble = disp_value_q[4*int'(idx_q) +: 4];

    an_n_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_n_d = blank ? 7'h7F : ~glyph(nibble);
    dp_n_d  = blank ? 1'b1 : ~disp_dp_q[idx_q];
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_value_q <= '0;
      disp_dp_q    <= '0;
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_value_q <= disp_value_d;
      disp_dp_q    <= disp_dp_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits and a 4-clock dwell;
// expected glyphs are hand-computed constants.
module tb_seg7_scan_driver;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4*N-1:0] value;
  logic [N-1:0] dp;
  logic         load;
  logic         blank_lz;
  logic [6:0]   seg_n;
  logic         dp_n;
  logic [N-1:0] an_n;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
    .blank_lz(blank_lz), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    check("frame_wait", {31'd0, frame_done}, 32'd1);
  endtask

  // Checks one full frame starting the edge after a boundary; segs packed {d3,d2,d1,d0}.
  task automatic scan(input string tag, input logic [27:0] segs, input logic [3:0] dpn,
                      input logic [3:0] blank);
    logic [3:0] an_exp;
    for (int d = 0; d < N; d++) begin
      an_exp = blank[d] ? 4'hF : ~(4'b0001 << d);
      for (int k = 0; k < D; k++) begin
        tick(1);
        check({tag, "_an"},  {28'd0, an_n},  {28'd0, an_exp});
        check({tag, "_seg"}, {25'd0, seg_n}, {25'd0, segs[7*d +: 7]});
        check({tag, "_dp"},  {31'd0, dp_n},  {31'd0, dpn[d]});
      end
    end
    check({tag, "_fdone"}, {31'd0, frame_done}, 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; load = 1'b1; value = 16'hFFFF; dp = 4'hF; blank_lz = 1'b0;
    tick(3);
    check("rst_an",  {28'd0, an_n},  32'hF);
    check("rst_seg", {25'd0, seg_n}, 32'h7F);
    check("rst_dp",  {31'd0, dp_n},  32'd1);
    check("rst_fd",  {31'd0, frame_done}, 32'd0);

    rst_n = 1'b1; load = 1'b0; value = '0; dp = '0;
    tick(1);
    check("rel_an",  {28'd0, an_n},  32'hE);
    check("rel_seg", {25'd0, seg_n}, 32'h40);
    check("rel_fd",  {31'd0, frame_done}, 32'd0);
    n = 1;
    while (frame_done !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    check("first_frame_len", n, 32'd16);

    do_load(16'h12AF, 4'b0100);
    wait_frame();
    scan("hex12AF", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011, 4'b0000);

    blank_lz = 1'b1;
    do_load(16'h0070, 4'b1111);
    wait_frame();
    scan("lz0070", {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1100, 4'b1100);
    do_load(16'h0000, 4'b0000);
    wait_frame();
    scan("lz0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, 4'b1110);
    blank_lz = 1'b0;

    tick(5);
    do_load(16'h1111, 4'b1111);
    tick(2);
    do_load(16'h2222, 4'b0000);
    check("old_frame_an",  {28'd0, an_n},  32'hB);
    check("old_frame_seg", {25'd0, seg_n}, 32'h40);
    wait_frame();
    scan("last_wins", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111, 4'b0000);

    tick(15);
    do_load(16'h3333, 4'b0101);
    check("bypass_fd", {31'd0, frame_done}, 32'd1);
    scan("bypass", {7'h30, 7'h30, 7'h30, 7'h30}, 4'b1010, 4'b0000);
    scan("bypass_hold", {7'h30, 7'h30, 7'h30, 7'h30}, 4'b1010, 4'b0000);

    tick(3);
    do_load(16'h5555, 4'b1111);
    tick(5);
    rst_n = 1'b0;
    tick(1);
    check("midrst_an",  {28'd0, an_n},  32'hF);
    check("midrst_seg", {25'd0, seg_n}, 32'h7F);
    check("midrst_dp",  {31'd0, dp_n},  32'd1);
    rst_n = 1'b1;
    tick(1);
    check("midrel_seg", {25'd0, seg_n}, 32'h40);
    wait_frame();
    scan("discard", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
